offset_to_vector_assembler: RTL and testbench

Read-return path between the byte-serial cache/memory controller and the RISC-V load port. It accepts a begin/end byte-offset pair from the controller and collects begin..end bytes, one per handshake, into a 32-bit word. It regenerates the contiguous byte-enable vector for that range and delivers the word and vector to the core over a valid/ready handshake.

---
 rtl/offset_to_vector_assembler_pkg.sv | 37 +++
 rtl/offset_to_vector_assembler_mask.sv | 28 ++
 rtl/offset_to_vector_assembler.sv | 162 ++++++++++++++++
 tb/tb_offset_to_vector_assembler.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/offset_to_vector_assembler_pkg.sv
// -----------------------------------------------------------------------------
// offset_to_vector_assembler_pkg
// Shared definitions for the byte-offset <-> byte-enable mapping used by the
// load read-return path (this block) and the store encoding side.
//   - default geometry: offset width, lanes per word, bits per lane
//   - state_t: assembler FSM states
//   - range_to_vector(): contiguous lane mask for begin..end, 0 if begin > end
// -----------------------------------------------------------------------------
package offset_to_vector_assembler_pkg;

   localparam int DEF_OFFSET_SIZE = 2;
   localparam int DEF_VECTOR_SIZE = 4;   // always 2**DEF_OFFSET_SIZE
   localparam int DEF_BYTE_WIDTH  = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DONE    = 2'd2
   } state_t;

   function automatic logic [DEF_VECTOR_SIZE-1:0] range_to_vector(
      input logic [DEF_OFFSET_SIZE-1:0] begin_off,
      input logic [DEF_OFFSET_SIZE-1:0] end_off
   );
      logic [DEF_VECTOR_SIZE-1:0] mask;
      mask = '0;
      if (begin_off <= end_off) begin
         for (int i = 0; i < DEF_VECTOR_SIZE; i++) begin
            if ((i >= int'(begin_off)) && (i <= int'(end_off))) begin
               mask[i] = 1'b1;
            end
         end
      end
      return mask;
   endfunction

endpackage

// File: rtl/offset_to_vector_assembler_mask.sv
// -----------------------------------------------------------------------------
// offset_range_mask
// Combinational begin/end offset to contiguous byte-enable generator.
// Ports:
//   begin_offset  first lane of the range
//   end_offset    last lane of the range, inclusive
//   vector        one bit per lane, set for begin..end; all zero if begin > end
// -----------------------------------------------------------------------------
module offset_range_mask
   import offset_to_vector_assembler_pkg::*;
#(
   parameter int OFFSET_SIZE = DEF_OFFSET_SIZE,
   parameter int VECTOR_SIZE = DEF_VECTOR_SIZE
)(
   input  logic [OFFSET_SIZE-1:0] begin_offset,
   input  logic [OFFSET_SIZE-1:0] end_offset,
   output logic [VECTOR_SIZE-1:0] vector
);

   logic legal;
   assign legal = (begin_offset <= end_offset);

   for (genvar gi = 0; gi < VECTOR_SIZE; gi++) begin : g_lane
      localparam logic [OFFSET_SIZE-1:0] LANE = OFFSET_SIZE'(gi);
      assign vector[gi] = legal && (LANE >= begin_offset) && (LANE <= end_offset);
   end

endmodule

// File: rtl/offset_to_vector_assembler.sv
// -----------------------------------------------------------------------------
// offset_to_vector_assembler
// Read-return path from the byte-serial memory controller to the load port.
// Takes a begin/end lane range, collects one byte per handshake into the
// addressed lanes of a word, and hands word + byte-enable vector to the core.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            range handshake (begin_offset, end_offset)
//   byte_valid/byte_ready          data byte handshake (byte_data)
//   word_valid/word_ready          result handshake (word_data, vector, error)
//   error                          begin > end; no bytes are consumed
// Optional build macro LOAD_ALIGN_EN: adds req_signed and presents word_data
// right-justified (lane begin at bit 0), zero- or sign-extended from lane end.
// VECTOR_SIZE must equal 2**OFFSET_SIZE.
// -----------------------------------------------------------------------------
module offset_to_vector_assembler
   import offset_to_vector_assembler_pkg::*;
#(
   parameter int OFFSET_SIZE = DEF_OFFSET_SIZE,
   parameter int VECTOR_SIZE = DEF_VECTOR_SIZE,
   parameter int BYTE_WIDTH  = DEF_BYTE_WIDTH
)(
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              req_valid,
   output logic                              req_ready,
   input  logic [OFFSET_SIZE-1:0]            begin_offset,
   input  logic [OFFSET_SIZE-1:0]            end_offset,
`ifdef LOAD_ALIGN_EN
   input  logic                              req_signed,
`endif
   input  logic                              byte_valid,
   output logic                              byte_ready,
   input  logic [BYTE_WIDTH-1:0]             byte_data,
   output logic                              word_valid,
   input  logic                              word_ready,
   output logic [VECTOR_SIZE*BYTE_WIDTH-1:0] word_data,
   output logic [VECTOR_SIZE-1:0]            vector,
   output logic                              error
);

   localparam int WORD_WIDTH = VECTOR_SIZE * BYTE_WIDTH;

   state_t                  state_reg, state_next;
   logic [OFFSET_SIZE-1:0]  counter_reg, end_reg;
   logic [WORD_WIDTH-1:0]   word_reg, word_next;
   logic [VECTOR_SIZE-1:0]  vector_reg, range_mask;
   logic                    error_reg;
   logic                    range_illegal, req_fire, byte_fire, last_byte;

   assign range_illegal = (begin_offset > end_offset);
   assign req_fire      = req_valid && req_ready;
   assign byte_fire     = byte_valid && byte_ready;
   assign last_byte     = (counter_reg == end_reg);

   offset_range_mask #(
      .OFFSET_SIZE (OFFSET_SIZE),
      .VECTOR_SIZE (VECTOR_SIZE)
   ) u_mask (
      .begin_offset (begin_offset),
      .end_offset   (end_offset),
      .vector       (range_mask)
   );

   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      req_ready  = 1'b0;
      byte_ready = 1'b0;
      word_valid = 1'b0;
      case (state_reg)
         IDLE: begin
            req_ready = 1'b1;
            // An illegal range skips collection and reports immediately.
            if (req_valid) state_next = range_illegal ? DONE : COLLECT;
         end
         COLLECT: begin
            byte_ready = 1'b1;
            if (byte_valid && last_byte) state_next = DONE;
         end
         DONE: begin
            word_valid = 1'b1;
            if (word_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Incoming byte lands only in the lane the counter points at.
   for (genvar gi = 0; gi < VECTOR_SIZE; gi++) begin : g_write
      localparam logic [OFFSET_SIZE-1:0] LANE = OFFSET_SIZE'(gi);
      assign word_next[gi*BYTE_WIDTH +: BYTE_WIDTH] =
         (counter_reg == LANE) ? byte_data : word_reg[gi*BYTE_WIDTH +: BYTE_WIDTH];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         counter_reg <= '0;
         end_reg     <= '0;
         word_reg    <= '0;
         vector_reg  <= '0;
         error_reg   <= 1'b0;
      end else begin
         if (req_fire) begin
            word_reg    <= '0;
            vector_reg  <= range_mask;
            error_reg   <= range_illegal;
            counter_reg <= begin_offset;
            end_reg     <= end_offset;
         end
         if (byte_fire) begin
            word_reg <= word_next;
            // Stop at end: end <= VECTOR_SIZE-1 so the counter never wraps.
            if (!last_byte) counter_reg <= counter_reg + 1'b1;
         end
         if (word_valid && word_ready) error_reg <= 1'b0;
      end
   end

   assign vector = vector_reg;
   assign error  = error_reg;

`ifdef LOAD_ALIGN_EN
   logic                    signed_reg;
   logic [OFFSET_SIZE-1:0]  begin_reg, span;
   logic [VECTOR_SIZE-1:0]  lane_msb, lane_fill;
   logic                    sign_bit;
   logic [WORD_WIDTH-1:0]   shifted, fill_bits;

   always_ff @(posedge clk) begin
      if (rst) begin
         signed_reg <= 1'b0;
         begin_reg  <= '0;
      end else if (req_fire) begin
         signed_reg <= req_signed;
         begin_reg  <= begin_offset;
      end
   end

   // Lanes outside the range are zero, so a logical shift leaves the upper
   // part zero-filled; sign fill is OR-ed in above the last valid lane.
   assign span     = end_reg - begin_reg;
   assign shifted  = word_reg >> (begin_reg * BYTE_WIDTH);
   assign sign_bit = signed_reg && lane_msb[end_reg];

   for (genvar gi = 0; gi < VECTOR_SIZE; gi++) begin : g_align
      localparam logic [OFFSET_SIZE-1:0] LANE = OFFSET_SIZE'(gi);
      assign lane_msb[gi]  = word_reg[gi*BYTE_WIDTH + BYTE_WIDTH - 1];
      assign lane_fill[gi] = (LANE > span);
      assign fill_bits[gi*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{sign_bit && lane_fill[gi]}};
   end

   assign word_data = (state_reg == DONE && !error_reg) ? (shifted | fill_bits) : word_reg;
`else
   assign word_data = word_reg;
`endif

endmodule

// File: tb/tb_offset_to_vector_assembler.sv
// -----------------------------------------------------------------------------
// tb_offset_to_vector_assembler
// Directed and randomized transactions against a lane-level reference model.
// Build with LOAD_ALIGN_EN defined to exercise the aligned/sign-extended path.
// -----------------------------------------------------------------------------
module tb_offset_to_vector_assembler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  begin_offset = 2'd0;
   logic [1:0]  end_offset = 2'd0;
`ifdef LOAD_ALIGN_EN
   logic        req_signed = 1'b0;
`endif
   logic        byte_valid = 1'b0;
   logic        byte_ready;
   logic [7:0]  byte_data = 8'd0;
   logic        word_valid;
   logic        word_ready = 1'b0;
   logic [31:0] word_data;
   logic [3:0]  vector;
   logic        error;

   int pass_cnt  = 0;
   int check_cnt = 0;

   always #5 clk = ~clk;

   offset_to_vector_assembler dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .begin_offset (begin_offset),
      .end_offset   (end_offset),
`ifdef LOAD_ALIGN_EN
      .req_signed   (req_signed),
`endif
      .byte_valid   (byte_valid),
      .byte_ready   (byte_ready),
      .byte_data    (byte_data),
      .word_valid   (word_valid),
      .word_ready   (word_ready),
      .word_data    (word_data),
      .vector       (vector),
      .error        (error)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Reference: bytes of lanes b..e, everything else zero; optionally
   // right-justified and extended from the top byte of the range.
   function automatic logic [31:0] model_word(input int b, input int e,
                                              input logic [31:0] d, input bit sgn);
      logic [31:0] w;
      int nbits;
      w = 32'd0;
      if (b > e) return 32'd0;
      for (int i = b; i <= e; i++) w[8*i +: 8] = d[8*i +: 8];
`ifdef LOAD_ALIGN_EN
      nbits = 8 * (e - b + 1);
      w = w >> (8 * b);
      if (sgn && w[nbits-1]) w = w | (32'hFFFF_FFFF << nbits);
`else
      nbits = 0;
      if (sgn && nbits != 0) w = 32'd0;
`endif
      return w;
   endfunction

   function automatic logic [3:0] model_vec(input int b, input int e);
      int m;
      if (b > e) return 4'd0;
      m = (1 << (e + 1)) - (1 << b);
      return m[3:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_txn(input int b, input int e, input logic [31:0] d,
                          input int stall, input int wait_cyc, input bit sgn,
                          input string tag);
      logic [31:0] ew;
      logic [3:0]  ev;
      logic        ee;
      ew = model_word(b, e, d, sgn);
      ev = model_vec(b, e);
      ee = (b > e);
      check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      req_valid    = 1'b1;
      begin_offset = 2'(b);
      end_offset   = 2'(e);
`ifdef LOAD_ALIGN_EN
      req_signed   = sgn;
`endif
      tick();
      req_valid    = 1'b0;
      begin_offset = 2'($urandom_range(0, 3));
      end_offset   = 2'($urandom_range(0, 3));
      if (!ee) begin
         for (int i = b; i <= e; i++) begin
            if (i > b) begin
               for (int s = 0; s < stall; s++) begin
                  byte_valid = 1'b0;
                  tick();
                  check({tag, "_stall_byte_ready"}, 32'(byte_ready), 32'd1);
               end
            end
            check({tag, "_collect_byte_ready"}, 32'(byte_ready), 32'd1);
            check({tag, "_collect_word_valid"}, 32'(word_valid), 32'd0);
            byte_valid = 1'b1;
            byte_data  = d[8*i +: 8];
            tick();
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
         end
      end else begin
         check({tag, "_illegal_byte_ready"}, 32'(byte_ready), 32'd0);
      end
      // Backpressure; stray bytes offered here must be ignored.
      for (int w = 0; w < wait_cyc; w++) begin
         check({tag, "_hold_valid"}, 32'(word_valid), 32'd1);
         check({tag, "_hold_data"}, word_data, ew);
         check({tag, "_hold_vector"}, 32'(vector), 32'(ev));
         check({tag, "_hold_error"}, 32'(error), 32'(ee));
         byte_valid = 1'b1;
         byte_data  = 8'($urandom);
         tick();
         byte_valid = 1'b0;
      end
      check({tag, "_word_valid"}, 32'(word_valid), 32'd1);
      check({tag, "_word_data"}, word_data, ew);
      check({tag, "_vector"}, 32'(vector), 32'(ev));
      check({tag, "_error"}, 32'(error), 32'(ee));
      check({tag, "_done_byte_ready"}, 32'(byte_ready), 32'd0);
      check({tag, "_done_req_ready"}, 32'(req_ready), 32'd0);
      word_ready = 1'b1;
      tick();
      word_ready = 1'b0;
      check({tag, "_post_word_valid"}, 32'(word_valid), 32'd0);
      check({tag, "_post_req_ready"}, 32'(req_ready), 32'd1);
      check({tag, "_post_error"}, 32'(error), 32'd0);
      $display("txn %s begin=%0d end=%0d signed=%0d word=%h vector=%b", tag, b, e, sgn, ew, ev);
   endtask

   initial begin
      // Reset
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_byte_ready", 32'(byte_ready), 32'd0);
      check("rst_word_valid", 32'(word_valid), 32'd0);
      check("rst_word_data", word_data, 32'd0);
      check("rst_vector", 32'(vector), 32'd0);
      check("rst_error", 32'(error), 32'd0);

      // Directed cases
      run_txn(0, 3, 32'h4433_2211, 0, 0, 1'b0, "full");
      run_txn(1, 2, 32'h00BB_AA00, 3, 2, 1'b0, "partial");
      run_txn(3, 3, 32'h5A00_0000, 0, 0, 1'b0, "single3");
      run_txn(0, 0, 32'h0000_00C3, 0, 1, 1'b0, "single0");
      run_txn(2, 1, 32'hDEAD_BEEF, 0, 1, 1'b0, "illegal");

      // Reset in the middle of collection drops the transfer
      req_valid    = 1'b1;
      begin_offset = 2'd0;
      end_offset   = 2'd3;
      tick();
      req_valid    = 1'b0;
      for (int i = 0; i < 2; i++) begin
         byte_valid = 1'b1;
         byte_data  = 8'(8'h61 + i);
         tick();
      end
      rst        = 1'b1;
      byte_data  = 8'h77;
      tick();
      rst        = 1'b0;
      byte_valid = 1'b0;
      check("midrst_req_ready", 32'(req_ready), 32'd1);
      check("midrst_byte_ready", 32'(byte_ready), 32'd0);
      check("midrst_word_valid", 32'(word_valid), 32'd0);
      check("midrst_vector", 32'(vector), 32'd0);
      check("midrst_word_data", word_data, 32'd0);
      $display("txn midrst dropped after 2 bytes");
      run_txn(0, 3, 32'h0403_0201, 1, 0, 1'b0, "after_rst");

      // Sign/zero extension cases (lane-positioned in the default build)
      run_txn(2, 2, 32'h0080_0000, 0, 0, 1'b1, "sx_lane2");
      run_txn(2, 2, 32'h0080_0000, 0, 0, 1'b0, "zx_lane2");
      run_txn(0, 1, 32'h0000_1234, 0, 0, 1'b1, "sx_half");
      run_txn(1, 3, 32'hF0E1_D200, 0, 1, 1'b1, "sx_upper");

      // Randomized transactions, including illegal ranges
      for (int n = 0; n < 30; n++) begin
         int rb, re, rs, rw;
         bit sg;
         logic [31:0] rd;
         rb = int'($urandom_range(0, 3));
         re = int'($urandom_range(0, 3));
         rs = int'($urandom_range(0, 2));
         rw = int'($urandom_range(0, 2));
         sg = 1'($urandom_range(0, 1));
         rd = $urandom;
         run_txn(rb, re, rd, rs, rw, sg, $sformatf("rand%0d", n));
      end

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
